// File: rtl/latsnq_bank_wr_seq_if.sv
// Bus-side and latch-side signal bundle for the latch bank write sequencer.
// Handshake: a requester holds req high until its done pulse; init is a level held until init_done.
interface latsnq_bank_wr_seq_if #(
    parameter int NREQ   = 4,
    parameter int NWORDS = 8,
    parameter int WIDTH  = 8
);
    localparam int AW = $clog2(NWORDS);

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  init;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  init_done;
    logic                  busy;
    logic [WIDTH-1:0]      d;
    logic [NWORDS-1:0]     e;
    logic [NWORDS-1:0]     setn;

    modport master (
        output req, addr, wdata, init,
        input  gnt, done, init_done, busy, d, e, setn
    );

    modport slave (
        input  req, addr, wdata, init,
        output gnt, done, init_done, busy, d, e, setn
    );
endinterface

// File: rtl/latsnq_bank_wr_seq.sv
// Round-robin write sequencer for a bank of set-able transparent latches (setup / E pulse / hold, plus SETN preset).
// Optional: LATSNQ_PRESET_ON_RESET_EN forces a bank preset on the first cycle after reset release.
module latsnq_bank_wr_seq #(
    parameter int NREQ      = 4,
    parameter int NWORDS    = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rn,
    latsnq_bank_wr_seq_if.slave    io_bus,
    output logic [2:0]             o_state
);
    localparam int AW   = $clog2(NWORDS);
    localparam int PW   = $clog2(NREQ);
    localparam int MAX1 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_FIN, S_PRESET, S_PREHOLD
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [AW-1:0]     r_addr;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_init_done;
    logic [WIDTH-1:0]  r_d;
    logic [NWORDS-1:0] r_e;
    logic [NWORDS-1:0] r_setn;

    logic [PW-1:0]     w_win;
    logic              w_found;
    logic              w_init;
    int                w_idx;

    // First set request searching upward from the slot after the last winner.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && io_bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

`ifdef LATSNQ_PRESET_ON_RESET_EN
    logic r_boot;

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) r_boot <= 1'b1;
        else       r_boot <= 1'b0;
    end

    assign w_init = io_bus.init | r_boot;
`else
    assign w_init = io_bus.init;
`endif

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= PW'(NREQ - 1);
            r_addr      <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_init_done <= 1'b0;
            r_d         <= '0;
            r_e         <= '0;
            r_setn      <= '1;
        end else begin
            r_done      <= '0;
            r_init_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_init) begin
                        r_state <= S_PRESET;
                        r_setn  <= '0;
                    end else if (w_found) begin
                        r_state <= S_SETUP;
                        r_ptr   <= w_win;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_d     <= io_bus.wdata[int'(w_win)*WIDTH +: WIDTH];
                        r_addr  <= io_bus.addr[int'(w_win)*AW +: AW];
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CW'(SETUP_CYC - 1)) begin
                        r_state <= S_PULSE;
                        r_cnt   <= '0;
                        // Out-of-range addresses run the full sequence without touching any word.
                        if (int'(r_addr) < NWORDS) r_e <= NWORDS'(1) << r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == CW'(PULSE_CYC - 1)) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                        r_e     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CW'(HOLD_CYC - 1)) begin
                        r_state <= S_FIN;
                        r_cnt   <= '0;
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_d     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                S_PRESET: begin
                    if (r_cnt == CW'(PULSE_CYC - 1)) begin
                        r_state <= S_PREHOLD;
                        r_cnt   <= '0;
                        r_setn  <= '1;
                        if (HOLD_CYC == 1) r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PREHOLD: begin
                    if (r_cnt == CW'(HOLD_CYC - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // init_done lands on the final PREHOLD cycle.
                        if (r_cnt == CW'(HOLD_CYC - 2)) r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.done      = r_done;
    assign io_bus.init_done = r_init_done;
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.d         = r_d;
    assign io_bus.e         = r_e;
    assign io_bus.setn      = r_setn;
    assign o_state          = r_state;
endmodule
